pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Generates per-stage enables and flushes, and operand forwarding selects for the EX stage.
- Consumes decode-derived control bits (load, we, store, BrOp) as they travel down the pipeline registers.
- Resolves load-use interlocks, branch/jump redirects, data-memory wait states and ecall/ebreak halt.

Parameters:
- MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before abort; range 1..255.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  REG_AW  source regs of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2
- ex_rd  in  REG_AW  dest of the instruction in EX
- ex_load  in  1  EX instruction is a load
- ex_we  in  1  EX instruction writes the register file
- ex_redirect  in  1  EX branch taken, or BrOp==5'b11111 (jal/jalr)
- ex_sys  in  1  EX instruction is ecall/ebreak
- ex_rs1, ex_rs2  in  REG_AW  sources of the instruction in EX
- mem_rd  in  REG_AW; mem_we  in  1; mem_load  in  1; mem_store  in  1  MEM-stage info
- wb_rd  in  REG_AW; wb_we  in  1  WB-stage info
- dmem_ready  in  1  data memory completes the access this cycle
- resume  in  1  single-cycle pulse that leaves HALT
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  stage register enables
- if_id_flush, id_ex_flush  out  1  insert bubble (synchronous clear of the stage register)
- pc_sel_redirect  out  1  PC loads the EX target
- fwd_a, fwd_b  out  2  00 = RF, 01 = MEM result, 10 = WB result
- mem_err  out  1  sticky timeout flag
- halted  out  1  core is in HALT

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT. Reset state is RUN.
- Reset values: all enables 1, flushes 0, pc_sel_redirect 0, fwd 00, mem_err 0, halted 0, wait counter 0.
- Stage outputs are combinational from state plus inputs; the state, wait counter and mem_err are registered.
- Priority, highest first: reset > memory wait > halt > redirect > load-use.
- Memory wait:
  - Condition: (mem_load|mem_store) & !dmem_ready. All five enables = 0 and no flush is asserted.
  - In RUN: enter MEM_WAIT next cycle; counter <= 1.
  - In MEM_WAIT: counter increments each cycle. On dmem_ready, return to RUN with the counter cleared.
  - When the counter reaches MEM_TIMEOUT: set mem_err, force-release to RUN, and treat the access as complete.
  - mem_err clears only on reset.
  - ex_redirect or ex_sys arriving during a wait is held, because the stages are frozen, and acted on in the first RUN cycle.
- Halt:
  - Trigger: ex_sys in RUN with no memory wait.
  - EX/MEM/WB drain for that cycle. pc_en = if_id_en = id_ex_en = 0. id_ex_flush = 1, so the ecall retires and a bubble follows.
  - Next state is HALT: all enables 0, halted = 1. resume returns the FSM to RUN the following cycle.
  - If resume and ex_sys occur in the same cycle, resume wins.
- Redirect:
  - Active when ex_redirect is high in RUN.
  - Outputs: pc_sel_redirect = 1, if_id_flush = 1, id_ex_flush = 1, all enables 1.
  - Lasts 1 cycle with 2 bubbles. A load-use condition in the same cycle is ignored.
- Load-use:
  - Condition: ex_load & ex_we & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
  - Outputs: pc_en = if_id_en = 0, id_ex_flush = 1. Exactly one stall cycle.
- Forwarding (per operand):
  - Select 01 if mem_we & !mem_load & mem_rd != 0 & mem_rd == ex_rsX.
  - Else select 10 if wb_we & wb_rd != 0 & wb_rd == ex_rsX.
  - Else select 00. MEM has priority over WB.
  - Selects are valid in every state; they do not matter while EX is frozen.
- x0 is never a hazard or a forwarding source.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- With it: three 32-bit saturating output counters.
  - perf_stall_cyc: load-use cycles.
  - perf_flush_cnt: redirect events.
  - perf_memwait_cyc: MEM_WAIT cycles.
  - All reset to 0; they do not count in HALT.
- Without it: the ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum (RUN/MEM_WAIT/HALT);
  - fwd select constants FWD_RF/FWD_MEM/FWD_WB;
  - BrOp constant BROP_JUMP = 5'b11111;
  - REG_AW default.
- One sub-module, pipe_fwd_unit: purely combinational fwd_a/fwd_b logic, instantiated once.

Test Plan:
- Load-use: lw x5 in EX (ex_rd = 5, ex_load = 1), add using x5 in ID → one cycle pc_en = 0, id_ex_flush = 1, then normal flow.
- Redirect plus load-use in the same cycle: ex_redirect = 1 and the load-use condition true → pc_sel_redirect = 1, both flushes = 1, pc_en = 1, no stall.
- Memory wait: mem_load = 1, dmem_ready low for 3 cycles → enables 0 for 3 cycles, RUN on the 4th. With MEM_TIMEOUT = 4 and ready never rising → mem_err = 1 after 4 wait cycles, then RUN.
- Halt: ex_sys = 1 → halted = 1 the next cycle with enables 0. resume pulse → halted = 0 and enables 1 the next cycle.
- Forwarding: mem_rd = wb_rd = ex_rs1 = 7, mem_we = wb_we = 1 → fwd_a = 01. Then mem_load = 1 → fwd_a = 10. Then rd = 0 → fwd_a = 00.
- Reset mid-MEM_WAIT: assert rst_n = 0 → all outputs return to reset values immediately, state RUN, counter 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        HALT     = 2'b10
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [4:0] BROP_JUMP = 5'b11111;

    localparam int REG_AW_DEF = 5;

    // jal/jalr decode helper for the EX-stage redirect source
    function automatic logic is_jump(input logic [4:0] brop);
        return brop == BROP_JUMP;
    endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// EX-stage operand forwarding selects; MEM result beats WB result, x0 never forwards.
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic              mem_load,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    // A load's data is not ready in MEM, so only ALU results forward from there
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (mem_we && !mem_load && (mem_rd != '0) && (mem_rd == rs))
            return FWD_MEM;
        else if (wb_we && (wb_rd != '0) && (wb_rd == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign fwd_a = fwd_sel(ex_rs1);
    assign fwd_b = fwd_sel(ex_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stalls, flushes, memory waits, halt and forwarding.
// Optional PIPE_HAZARD_PERF_EN adds saturating performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int REG_AW      = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_load,
    input  logic              ex_we,
    input  logic              ex_redirect,
    input  logic              ex_sys,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic              mem_load,
    input  logic              mem_store,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    input  logic              dmem_ready,
    input  logic              resume,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              pc_sel_redirect,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_err,
    output logic              halted
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stall_cyc,
    output logic [31:0]       perf_flush_cnt,
    output logic [31:0]       perf_memwait_cyc
`endif
);

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt, wait_cnt_nxt;
    logic        mem_err_nxt;
    logic [4:0]  stage_en;
    logic        timeout, mem_stall, load_use, halt_trig;
    logic        load_use_act, redirect_act;

    assign timeout   = (state == MEM_WAIT) && (wait_cnt == 8'(MEM_TIMEOUT));
    // On timeout the access is treated as done even though ready never came
    assign mem_stall = (mem_load | mem_store) & ~dmem_ready & ~timeout;
    assign load_use  = ex_load & ex_we & (ex_rd != '0) &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign halt_trig = ex_sys & ~resume;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            mem_err  <= mem_err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        mem_err_nxt     = mem_err;
        stage_en        = 5'b11111;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        pc_sel_redirect = 1'b0;
        load_use_act    = 1'b0;
        redirect_act    = 1'b0;
        case (state)
            RUN, MEM_WAIT: begin
                if (mem_stall) begin
                    stage_en = 5'b00000;
                    if (state == RUN) begin
                        state_nxt    = MEM_WAIT;
                        wait_cnt_nxt = 8'd1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 8'd1;
                    end
                end else begin
                    // Release cycle of a wait behaves as RUN so held redirect/sys act now
                    if (state == MEM_WAIT) begin
                        state_nxt    = RUN;
                        wait_cnt_nxt = '0;
                        if (timeout)
                            mem_err_nxt = 1'b1;
                    end
                    if (halt_trig) begin
                        stage_en    = 5'b00011;
                        id_ex_flush = 1'b1;
                        state_nxt   = HALT;
                    end else if (ex_redirect) begin
                        pc_sel_redirect = 1'b1;
                        if_id_flush     = 1'b1;
                        id_ex_flush     = 1'b1;
                        redirect_act    = 1'b1;
                    end else if (load_use) begin
                        stage_en     = 5'b00111;
                        id_ex_flush  = 1'b1;
                        load_use_act = 1'b1;
                    end
                end
            end
            HALT: begin
                stage_en = 5'b00000;
                if (resume)
                    state_nxt = RUN;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = stage_en;
    assign halted = (state == HALT);

    pipe_fwd_unit #(
        .REG_AW (REG_AW)
    ) u_fwd (
        .ex_rs1   (ex_rs1),
        .ex_rs2   (ex_rs2),
        .mem_rd   (mem_rd),
        .mem_we   (mem_we),
        .mem_load (mem_load),
        .wb_rd    (wb_rd),
        .wb_we    (wb_we),
        .fwd_a    (fwd_a),
        .fwd_b    (fwd_b)
    );

`ifdef PIPE_HAZARD_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cyc   <= '0;
            perf_flush_cnt   <= '0;
            perf_memwait_cyc <= '0;
        end else begin
            if (load_use_act)
                perf_stall_cyc <= sat_inc(perf_stall_cyc);
            if (redirect_act)
                perf_flush_cnt <= sat_inc(perf_flush_cnt);
            if (state == MEM_WAIT)
                perf_memwait_cyc <= sat_inc(perf_memwait_cyc);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expectations (MEM_TIMEOUT = 4).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_load, ex_we, ex_redirect, ex_sys;
    logic       mem_we, mem_load, mem_store, wb_we, dmem_ready, resume;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, pc_sel_redirect, mem_err, halted;
    logic [1:0] fwd_a, fwd_b;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_memwait_cyc;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_load(ex_load), .ex_we(ex_we), .ex_redirect(ex_redirect),
        .ex_sys(ex_sys), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_load(mem_load), .mem_store(mem_store),
        .wb_rd(wb_rd), .wb_we(wb_we), .dmem_ready(dmem_ready), .resume(resume),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .pc_sel_redirect(pc_sel_redirect), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_err(mem_err), .halted(halted)
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt),
        .perf_memwait_cyc(perf_memwait_cyc)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // enables {pc,if_id,id_ex,ex_mem,mem_wb}, flushes {if_id,id_ex}
    task automatic ctrl(input string tag, input logic [4:0] en, input logic [1:0] fl,
                        input logic sel, input logic hlt);
        chk({tag, ".en"}, 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(en));
        chk({tag, ".fl"}, 32'({if_id_flush, id_ex_flush}), 32'(fl));
        chk({tag, ".sel"}, 32'(pc_sel_redirect), 32'(sel));
        chk({tag, ".halt"}, 32'(halted), 32'(hlt));
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_load = 0; ex_we = 0; ex_redirect = 0; ex_sys = 0;
        ex_rs1 = 0; ex_rs2 = 0; mem_rd = 0; mem_we = 0; mem_load = 0; mem_store = 0;
        wb_rd = 0; wb_we = 0; dmem_ready = 0; resume = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        #1 rst_n = 1'b0;
        #2;
        ctrl("reset", 5'b11111, 2'b00, 1'b0, 1'b0);
        chk("reset.fwd", 32'({fwd_a, fwd_b}), 32'h0);
        chk("reset.err", 32'(mem_err), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        #1 ctrl("run_idle", 5'b11111, 2'b00, 1'b0, 1'b0);

        // load-use: lw x5 in EX, consumer of x5 in ID
        tick();
        ex_load = 1; ex_we = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        #1 ctrl("lduse", 5'b00111, 2'b01, 1'b0, 1'b0);
        tick();
        ex_load = 0; ex_we = 0;
        #1 ctrl("lduse_after", 5'b11111, 2'b00, 1'b0, 1'b0);
        tick();
        ex_load = 1; ex_we = 1; ex_rd = 0; id_rs1 = 0;
        #1 ctrl("lduse_x0", 5'b11111, 2'b00, 1'b0, 1'b0);
        tick();
        ex_rd = 9; id_rs1 = 1; id_rs2 = 9; id_use_rs2 = 0;
        #1 ctrl("lduse_rs2_unused", 5'b11111, 2'b00, 1'b0, 1'b0);
        tick();
        id_use_rs2 = 1;
        #1 ctrl("lduse_rs2", 5'b00111, 2'b01, 1'b0, 1'b0);

        // redirect beats load-use in the same cycle
        tick();
        ex_redirect = 1;
        #1 ctrl("redir_lduse", 5'b11111, 2'b11, 1'b1, 1'b0);

        // memory wait: ready low 3 cycles with redirect held, release on ready
        tick();
        idle();
        ex_redirect = 1; mem_load = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 ctrl($sformatf("memwait%0d", i), 5'b00000, 2'b00, 1'b0, 1'b0);
            tick();
        end
        dmem_ready = 1;
        #1 ctrl("memwait_release", 5'b11111, 2'b11, 1'b1, 1'b0);
        tick();
        idle();
        #1 ctrl("memwait_run", 5'b11111, 2'b00, 1'b0, 1'b0);
        chk("memwait_err", 32'(mem_err), 32'h0);

        // timeout: ready never rises, 4 frozen cycles then forced release
        tick();
        mem_store = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("tmo_frozen%0d", i),
                   32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'h0);
            tick();
        end
        #1 ctrl("tmo_release", 5'b11111, 2'b00, 1'b0, 1'b0);
        chk("tmo_err_pre", 32'(mem_err), 32'h0);
        tick();
        mem_store = 0;
        #1 chk("tmo_err", 32'(mem_err), 32'h1);
        ctrl("tmo_run", 5'b11111, 2'b00, 1'b0, 1'b0);
        tick();
        #1 chk("tmo_err_sticky", 32'(mem_err), 32'h1);

        // halt and resume
        tick();
        ex_sys = 1;
        #1 ctrl("halt_trig", 5'b00011, 2'b01, 1'b0, 1'b0);
        tick();
        ex_sys = 0;
        #1 ctrl("halted", 5'b00000, 2'b00, 1'b0, 1'b1);
        tick();
        resume = 1;
        #1 ctrl("halt_resume", 5'b00000, 2'b00, 1'b0, 1'b1);
        tick();
        resume = 0;
        #1 ctrl("resumed", 5'b11111, 2'b00, 1'b0, 1'b0);
        tick();
        ex_sys = 1; resume = 1;
        #1 ctrl("sys_resume", 5'b11111, 2'b00, 1'b0, 1'b0);
        tick();
        ex_sys = 0; resume = 0;
        #1 chk("sys_resume_nohalt", 32'(halted), 32'h0);

        // forwarding
        tick();
        dmem_ready = 1;
        ex_rs1 = 7; ex_rs2 = 3; mem_rd = 7; wb_rd = 7; mem_we = 1; wb_we = 1;
        #1 chk("fwd_a_mem", 32'(fwd_a), 32'h1);
        chk("fwd_b_rf", 32'(fwd_b), 32'h0);
        mem_load = 1; ex_rs2 = 7;
        #1 chk("fwd_a_wb", 32'(fwd_a), 32'h2);
        chk("fwd_b_wb", 32'(fwd_b), 32'h2);
        mem_load = 0; ex_rs2 = 4; wb_rd = 4;
        #1 chk("fwd_b_wb2", 32'(fwd_b), 32'h2);
        chk("fwd_a_mem2", 32'(fwd_a), 32'h1);
        mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
        #1 chk("fwd_a_x0", 32'(fwd_a), 32'h0);
        chk("fwd_b_x0", 32'(fwd_b), 32'h0);

        // reset in the middle of a memory wait
        tick();
        idle();
        mem_load = 1;
        tick();
        tick();
        #1 chk("rst_mid_frozen", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'h0);
        rst_n = 0;
        idle();
        #1 ctrl("rst_mid", 5'b11111, 2'b00, 1'b0, 1'b0);
        chk("rst_mid_err", 32'(mem_err), 32'h0);
        tick();
        rst_n = 1;
        tick();
        #1 ctrl("rst_mid_run", 5'b11111, 2'b00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
